digital_clk_timekeeper: RTL and testbench
=========================================

# digital_clk_timekeeper

Parametrised 24-hour timekeeper that counts ms/sec/min/hour from a configurable clock prescaler. Supports run/pause, range-checked time loading, 12/24-hour display mode, a minute-resolution alarm and rollover strobes. It feeds the display and alarm logic of the clock design.

## Interface
- CLK_PER_MS, default 1: clk_i cycles per millisecond tick, ≥1; 1 = one ms per clock.
- clk_i  in  1  system clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- run_i  in  1  1 = count; 0 = hold prescaler and time.
- mode_24_i  in  1  1 = 24-hour display, 0 = 12-hour display.
- set_valid_i  in  1  single-cycle load request.
- set_hour_i / set_min_i / set_sec_i  in  5/6/6  load value, always 24-hour encoding.
- alarm_en_i  in  1  alarm enable.
- alarm_hour_i / alarm_min_i  in  5/6  alarm time, 24-hour encoding.
- ms_o  out  10  0..999.
- sec_o / min_o  out  6  0..59.
- hour_o  out  5  0..23 (24h) or 1..12 (12h).
- pm_o  out  1  12h mode: 1 when internal hour ≥12; 0 in 24h mode.
- sec_tick_o / day_tick_o / alarm_o / set_err_o  out  1  single-cycle strobes.

## Operation
- Internal registers: presc, ms, sec, min, hour24 (0..23). Reset: all 0, so time is 00:00:00.000; hour_o = 0 (24h) or 12 (12h, pm_o=0); all strobes 0.
- Prescaler: when run_i=1, presc increments; at CLK_PER_MS−1 it wraps to 0 and asserts internal ms_tick that cycle. run_i=0 freezes presc and time, with no strobes.
- On ms_tick: ms+1. At 999: ms→0, sec+1, sec_tick_o=1. At sec 59: sec→0, min+1. At min 59: min→0, hour24+1. At 23:59:59.999: everything →0 and day_tick_o=1. No value ever exceeds its maximum.
- Load: if set_valid_i=1 and hour<24, min<60, sec<60, then on the next edge hour24/min/sec take the set values and ms and presc →0. The load overrides any ms_tick at that edge, and no rollover strobes fire. If any field is out of range, time is unchanged, the tick proceeds normally and set_err_o=1 for one cycle.
- Alarm: alarm_o=1 for one cycle when a counted ms_tick moves time to alarm_hour:alarm_min:00.000 and alarm_en_i=1. A load that lands exactly on the alarm time does not fire it. Out-of-range alarm values never match.
- Display decode (combinational from hour24 and mode_24_i): 24h passes hour24 through. 12h maps 0→12, 1..12→same, 13..23→hour24−12; pm_o = (hour24≥12).

## Timing
- Time registers and strobes are registered. They update on the edge where ms_tick is sampled and are visible the following cycle.
- CLK_PER_MS=1: ms_o advances every clock while run_i=1. General case: one ms step per CLK_PER_MS running cycles.
- sec_tick_o, day_tick_o and alarm_o coincide with the cycle the new time becomes visible. day_tick_o and sec_tick_o are both high at midnight.
- Load latency is 1 cycle. The counting after a load is a full CLK_PER_MS cycles to the next ms step.
- Asynchronous reset mid-count or mid-load clears immediately; the pending load is discarded.
- hour_o and pm_o follow mode_24_i combinationally, with no effect on the count.

## Structure
- Package digital_clk_pkg: MS_MAX=999, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, field widths, and a 12h-decode function.
- Sub-module ms_prescaler (param CLK_PER_MS; ports clk_i, reset_i, run_i, clear_i, tick_o) owns presc. The top holds the cascade, load check, alarm compare and decode.

## Test plan
- Reset with CLK_PER_MS=1, run_i=1: the outputs read 0:0:0.000, and after 1000 clocks sec_o=1, ms_o=0, sec_tick_o pulsed once.
- Load 23:59:59, run 1000 ms: the time reads 00:00:00.000, day_tick_o and sec_tick_o are high in the same cycle, and hour_o=0.
- set_valid_i with hour=24 (or min=60): time unchanged, set_err_o is a single pulse, counting continues without a gap.
- Alarm 07:30 enabled, load 07:29:59, run 1000 ms: alarm_o pulses once at 07:30:00.000. With alarm_en_i=0 no pulse. Loading 07:30:00 gives no pulse.
- mode_24_i=0 sweep: hour24=0→12/pm0, 12→12/pm1, 13→1/pm1, 23→11/pm1.
- CLK_PER_MS=4, toggle run_i low for 10 cycles mid-ms, then assert reset_i asynchronously mid-count: ms steps every 4 running cycles, the pause is honoured, and reset zeroes everything immediately.

Source files
------------

// File: rtl/digital_clk_pkg.sv
// Shared widths, field limits, time-of-day payload and 12-hour decode for the clock timekeeper.
package digital_clk_pkg;

    localparam int unsigned MS_W   = 10;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [MS_W-1:0]   MS_MAX   = MS_W'(999);
    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
    localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
    localparam logic [HOUR_W-1:0] NOON     = HOUR_W'(12);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
        logic [MS_W-1:0]   ms;
    } tod_t;

    // 0 -> 12, 1..12 unchanged, 13..23 -> hour - 12
    function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] hour24);
        logic [HOUR_W-1:0] disp;
        if (hour24 == '0) begin
            disp = NOON;
        end else if (hour24 > NOON) begin
            disp = hour24 - NOON;
        end else begin
            disp = hour24;
        end
        return disp;
    endfunction

endpackage

// File: rtl/digital_clk_timekeeper_ms_prescaler.sv
// Divides clk_i down to a one-cycle millisecond tick; frozen while run_i is low.
module ms_prescaler #(
    parameter int unsigned CLK_PER_MS = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);

    logic [PRESC_W-1:0] presc;

    // Tick is presented combinationally in the cycle presc sits at its last count.
    assign tick_o = run_i && (presc == PRESC_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc <= '0;
        end else if (clear_i) begin
            presc <= '0;
        end else if (run_i) begin
            presc <= tick_o ? '0 : presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/digital_clk_timekeeper.sv
// 24-hour ms/sec/min/hour timekeeper with range-checked load, minute alarm and 12/24h display decode.
module digital_clk_timekeeper
    import digital_clk_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              mode_24_i,
    input  logic              set_valid_i,
    input  logic [HOUR_W-1:0] set_hour_i,
    input  logic [MIN_W-1:0]  set_min_i,
    input  logic [SEC_W-1:0]  set_sec_i,
    input  logic              alarm_en_i,
    input  logic [HOUR_W-1:0] alarm_hour_i,
    input  logic [MIN_W-1:0]  alarm_min_i,
    output logic [MS_W-1:0]   ms_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              pm_o,
    output logic              sec_tick_o,
    output logic              day_tick_o,
    output logic              alarm_o,
    output logic              set_err_o
);

    tod_t tod_q;
    tod_t tod_d;
    tod_t alarm_tod;
    logic ms_tick;
    logic set_ok;
    logic alarm_valid;
    logic sec_wrap;
    logic day_wrap;
    logic alarm_hit;

    assign set_ok = set_valid_i && (set_hour_i <= HOUR_MAX)
                    && (set_min_i <= MIN_MAX) && (set_sec_i <= SEC_MAX);

    ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_presc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run_i   (run_i),
        .clear_i (set_ok),
        .tick_o  (ms_tick)
    );

    // Counting cascade: ms -> sec -> min -> hour24 -> midnight.
    always_comb begin
        tod_d    = tod_q;
        sec_wrap = 1'b0;
        day_wrap = 1'b0;
        if (ms_tick) begin
            if (tod_q.ms == MS_MAX) begin
                tod_d.ms = '0;
                sec_wrap = 1'b1;
                if (tod_q.second == SEC_MAX) begin
                    tod_d.second = '0;
                    if (tod_q.minute == MIN_MAX) begin
                        tod_d.minute = '0;
                        if (tod_q.hour == HOUR_MAX) begin
                            tod_d.hour = '0;
                            day_wrap   = 1'b1;
                        end else begin
                            tod_d.hour = tod_q.hour + HOUR_W'(1);
                        end
                    end else begin
                        tod_d.minute = tod_q.minute + MIN_W'(1);
                    end
                end else begin
                    tod_d.second = tod_q.second + SEC_W'(1);
                end
            end else begin
                tod_d.ms = tod_q.ms + MS_W'(1);
            end
        end
    end

    // Alarm only fires on a counted step into hh:mm:00.000, never on a load.
    assign alarm_valid = (alarm_hour_i <= HOUR_MAX) && (alarm_min_i <= MIN_MAX);
    assign alarm_tod   = '{hour: alarm_hour_i, minute: alarm_min_i, second: '0, ms: '0};
    assign alarm_hit   = ms_tick && alarm_en_i && alarm_valid && (tod_d == alarm_tod);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tod_q      <= '0;
            sec_tick_o <= 1'b0;
            day_tick_o <= 1'b0;
            alarm_o    <= 1'b0;
            set_err_o  <= 1'b0;
        end else begin
            set_err_o <= set_valid_i && !set_ok;
            if (set_ok) begin
                tod_q      <= '{hour: set_hour_i, minute: set_min_i, second: set_sec_i, ms: '0};
                sec_tick_o <= 1'b0;
                day_tick_o <= 1'b0;
                alarm_o    <= 1'b0;
            end else begin
                tod_q      <= tod_d;
                sec_tick_o <= sec_wrap;
                day_tick_o <= day_wrap;
                alarm_o    <= alarm_hit;
            end
        end
    end

    assign ms_o   = tod_q.ms;
    assign sec_o  = tod_q.second;
    assign min_o  = tod_q.minute;
    assign hour_o = mode_24_i ? tod_q.hour : hour_12h(tod_q.hour);
    assign pm_o   = !mode_24_i && (tod_q.hour >= NOON);

endmodule

// File: tb/tb_digital_clk_timekeeper.sv
// Scoreboard bench: stimulus queues expected snapshots/strobes, a negedge monitor pops and compares.
module tb_digital_clk_timekeeper;

    logic       clk_i = 1'b0;
    logic       reset_i, reset4, run_i, run4, mode_24_i, set_valid_i, alarm_en_i;
    logic [4:0] set_hour_i, alarm_hour_i;
    logic [5:0] set_min_i, set_sec_i, alarm_min_i;

    logic [9:0] ms_o, ms4;
    logic [5:0] sec_o, min_o, sec4, min4;
    logic [4:0] hour_o, hour4;
    logic       pm_o, sec_tick_o, day_tick_o, alarm_o, set_err_o;
    logic       pm4, sec_tick4, day_tick4, alarm4, set_err4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [28:0] snap_q[$];
    logic [30:0] strobe_q[$];
    logic [28:0] se, sa;
    logic [30:0] te, ta;

    always #5 clk_i = ~clk_i;

    digital_clk_timekeeper #(.CLK_PER_MS(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i), .mode_24_i(mode_24_i),
        .set_valid_i(set_valid_i), .set_hour_i(set_hour_i), .set_min_i(set_min_i),
        .set_sec_i(set_sec_i), .alarm_en_i(alarm_en_i), .alarm_hour_i(alarm_hour_i),
        .alarm_min_i(alarm_min_i), .ms_o(ms_o), .sec_o(sec_o), .min_o(min_o),
        .hour_o(hour_o), .pm_o(pm_o), .sec_tick_o(sec_tick_o), .day_tick_o(day_tick_o),
        .alarm_o(alarm_o), .set_err_o(set_err_o)
    );

    digital_clk_timekeeper #(.CLK_PER_MS(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset4), .run_i(run4), .mode_24_i(mode_24_i),
        .set_valid_i(set_valid_i), .set_hour_i(set_hour_i), .set_min_i(set_min_i),
        .set_sec_i(set_sec_i), .alarm_en_i(alarm_en_i), .alarm_hour_i(alarm_hour_i),
        .alarm_min_i(alarm_min_i), .ms_o(ms4), .sec_o(sec4), .min_o(min4),
        .hour_o(hour4), .pm_o(pm4), .sec_tick_o(sec_tick4), .day_tick_o(day_tick4),
        .alarm_o(alarm4), .set_err_o(set_err4)
    );

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Snapshot record: {dut4_sel, hour_o, pm_o, min, sec, ms}; compared at the next negedge.
    task automatic snap(input logic dsel, input logic [4:0] h, input logic pm,
                        input logic [5:0] m, input logic [5:0] s, input logic [9:0] ms);
        snap_q.push_back({dsel, h, pm, m, s, ms});
        @(negedge clk_i);
        #1;
    endtask

    // Strobe record: {sec_tick, day_tick, alarm, set_err, hour_o, min, sec, ms}.
    task automatic exp_strobe(input logic [3:0] st, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s, input logic [9:0] ms);
        strobe_q.push_back({st, h, m, s, ms});
    endtask

    always @(negedge clk_i) begin
        if (snap_q.size() != 0) begin
            se = snap_q.pop_front();
            sa = se[28] ? {1'b1, hour4, pm4, min4, sec4, ms4}
                        : {1'b0, hour_o, pm_o, min_o, sec_o, ms_o};
            check("snapshot", 31'(sa), 31'(se));
        end
        if (sec_tick_o || day_tick_o || alarm_o || set_err_o) begin
            ta = {sec_tick_o, day_tick_o, alarm_o, set_err_o, hour_o, min_o, sec_o, ms_o};
            if (strobe_q.size() == 0) check("strobe_unexpected", ta, 31'd0);
            else begin
                te = strobe_q.pop_front();
                check("strobe", ta, te);
            end
        end
        if (sec_tick4 || day_tick4 || alarm4 || set_err4)
            check("strobe_unexpected_dut4", 31'({sec_tick4, day_tick4, alarm4, set_err4}), 31'd0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] sw_h[4]    = '{5'd0, 5'd12, 5'd13, 5'd23};
        logic [4:0] sw_disp[4] = '{5'd12, 5'd12, 5'd1, 5'd11};
        logic       sw_pm[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};

        reset_i = 1'b1; reset4 = 1'b1; run_i = 1'b0; run4 = 1'b0; mode_24_i = 1'b1;
        set_valid_i = 1'b0; set_hour_i = '0; set_min_i = '0; set_sec_i = '0;
        alarm_en_i = 1'b0; alarm_hour_i = '0; alarm_min_i = '0;

        // Reset state in 24h and 12h display
        cyc(2);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd0);
        reset_i = 1'b0;
        cyc(1);
        snap(1'b0, 5'd0, 1'b0, 6'd0, 6'd0, 10'd0);
        mode_24_i = 1'b0;
        cyc(1);
        snap(1'b0, 5'd12, 1'b0, 6'd0, 6'd0, 10'd0);
        mode_24_i = 1'b1;

        // 1000 ms from zero -> one second, single sec_tick
        exp_strobe(4'b1000, 5'd0, 6'd0, 6'd1, 10'd0);
        run_i = 1'b1;
        cyc(1000);
        snap(1'b0, 5'd0, 1'b0, 6'd0, 6'd1, 10'd0);
        run_i = 1'b0;

        // Midnight rollover from 23:59:59
        set_hour_i = 5'd23; set_min_i = 6'd59; set_sec_i = 6'd59; set_valid_i = 1'b1;
        cyc(1);
        set_valid_i = 1'b0;
        snap(1'b0, 5'd23, 1'b0, 6'd59, 6'd59, 10'd0);
        exp_strobe(4'b1100, 5'd0, 6'd0, 6'd0, 10'd0);
        run_i = 1'b1;
        cyc(1000);
        snap(1'b0, 5'd0, 1'b0, 6'd0, 6'd0, 10'd0);
        run_i = 1'b0;

        // Out-of-range loads while counting: error pulse, no gap in counting
        set_hour_i = 5'd24; set_min_i = 6'd0; set_sec_i = 6'd0; set_valid_i = 1'b1; run_i = 1'b1;
        exp_strobe(4'b0001, 5'd0, 6'd0, 6'd0, 10'd1);
        cyc(1);
        set_valid_i = 1'b0;
        cyc(1);
        set_hour_i = 5'd5; set_min_i = 6'd60; set_valid_i = 1'b1;
        exp_strobe(4'b0001, 5'd0, 6'd0, 6'd0, 10'd3);
        cyc(1);
        set_valid_i = 1'b0;
        cyc(5);
        snap(1'b0, 5'd0, 1'b0, 6'd0, 6'd0, 10'd8);
        run_i = 1'b0;

        // Alarm 07:30 enabled
        alarm_hour_i = 5'd7; alarm_min_i = 6'd30; alarm_en_i = 1'b1;
        set_hour_i = 5'd7; set_min_i = 6'd29; set_sec_i = 6'd59; set_valid_i = 1'b1;
        cyc(1);
        set_valid_i = 1'b0;
        snap(1'b0, 5'd7, 1'b0, 6'd29, 6'd59, 10'd0);
        exp_strobe(4'b1010, 5'd7, 6'd30, 6'd0, 10'd0);
        run_i = 1'b1;
        cyc(1000);
        snap(1'b0, 5'd7, 1'b0, 6'd30, 6'd0, 10'd0);
        run_i = 1'b0;

        // Alarm disabled: only the second rolls
        alarm_en_i = 1'b0;
        set_valid_i = 1'b1;
        cyc(1);
        set_valid_i = 1'b0;
        exp_strobe(4'b1000, 5'd7, 6'd30, 6'd0, 10'd0);
        run_i = 1'b1;
        cyc(1000);
        snap(1'b0, 5'd7, 1'b0, 6'd30, 6'd0, 10'd0);
        run_i = 1'b0;

        // Load exactly onto alarm time with a tick pending: load wins, no alarm
        alarm_en_i = 1'b1;
        set_hour_i = 5'd7; set_min_i = 6'd30; set_sec_i = 6'd0; set_valid_i = 1'b1; run_i = 1'b1;
        cyc(1);
        set_valid_i = 1'b0; run_i = 1'b0;
        snap(1'b0, 5'd7, 1'b0, 6'd30, 6'd0, 10'd0);

        // 12-hour display sweep
        mode_24_i = 1'b0;
        set_min_i = 6'd0; set_sec_i = 6'd0;
        for (int i = 0; i < 4; i++) begin
            set_hour_i = sw_h[i]; set_valid_i = 1'b1;
            cyc(1);
            set_valid_i = 1'b0;
            snap(1'b0, sw_disp[i], sw_pm[i], 6'd0, 6'd0, 10'd0);
        end
        mode_24_i = 1'b1;
        cyc(1);
        snap(1'b0, 5'd23, 1'b0, 6'd0, 6'd0, 10'd0);

        // CLK_PER_MS=4: period, pause mid-ms, async reset
        reset4 = 1'b0; run4 = 1'b1;
        cyc(3);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd0);
        cyc(1);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd1);
        cyc(2);
        run4 = 1'b0;
        cyc(10);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd1);
        run4 = 1'b1;
        cyc(1);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd1);
        cyc(1);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd2);
        cyc(3);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd2);
        cyc(1);
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd3);
        cyc(2);
        #2;
        reset4 = 1'b1;
        snap(1'b1, 5'd0, 1'b0, 6'd0, 6'd0, 10'd0);

        cyc(2);
        check("strobes_pending", 31'(strobe_q.size()), 31'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
